// File: rtl/axil_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axil_rd_arbiter
// Purpose  : Two-requester AXI-Lite read-channel arbiter. Requester 0 is the
//            instruction fetch, requester 1 the load/store unit. One
//            outstanding transaction; the winning address is registered
//            before it is issued downstream.
// Options  : AXIL_RD_ARB_LSU_PRIORITY_EN - when defined, requester 1 wins
//            every tie (fixed priority). Otherwise ties are round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module axil_rd_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // requester 0 (instruction fetch)
    input  logic              s0_arvalid,
    input  logic [ADDR_W-1:0] s0_araddr,
    output logic              s0_arready,
    output logic              s0_rvalid,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    input  logic              s0_rready,
    // requester 1 (load/store)
    input  logic              s1_arvalid,
    input  logic [ADDR_W-1:0] s1_araddr,
    output logic              s1_arready,
    output logic              s1_rvalid,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    input  logic              s1_rready,
    // downstream memory read slave
    output logic              m_arvalid,
    output logic [ADDR_W-1:0] m_araddr,
    input  logic              m_arready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    output logic              m_rready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;       // requester owning the transaction
    logic              rr_last_q, rr_last_d;   // last requester granted
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              m_arvalid_q, m_arvalid_d;

    logic              any_req;
    logic              winner;
    logic              in_idle;
    logic              in_data;

    // Choose the requester that would be granted this cycle if in IDLE
    always_comb begin
        any_req = s0_arvalid | s1_arvalid;
        if (s0_arvalid && s1_arvalid) begin
`ifdef AXIL_RD_ARB_LSU_PRIORITY_EN
            winner = 1'b1;
`else
            winner = ~rr_last_q;
`endif
        end else begin
            winner = s1_arvalid;
        end
    end

    // Next-state and next-register values for the transaction sequencer
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_last_d   = rr_last_q;
        addr_d      = addr_q;
        m_arvalid_d = m_arvalid_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    addr_d      = winner ? s1_araddr : s0_araddr;
                    grant_d     = winner;
                    rr_last_d   = winner;
                    m_arvalid_d = 1'b1;
                    state_d     = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // address and valid are frozen until the slave takes them
                if (m_arready) begin
                    m_arvalid_d = 1'b0;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (m_rvalid && m_rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                m_arvalid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset returns straight to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= 1'b0;
            rr_last_q   <= 1'b1;
            addr_q      <= '0;
            m_arvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_last_q   <= rr_last_d;
            addr_q      <= addr_d;
            m_arvalid_q <= m_arvalid_d;
        end
    end

    // Handshake outputs: accept in IDLE, route response by grant in DATA
    always_comb begin
        in_idle    = (state_q == ST_IDLE);
        in_data    = (state_q == ST_DATA);
        // rst_n gate keeps arready low while reset is held in IDLE
        s0_arready = rst_n & in_idle & any_req & ~winner;
        s1_arready = rst_n & in_idle & any_req &  winner;
        m_arvalid  = m_arvalid_q;
        m_araddr   = addr_q;
        m_rready   = in_data & (grant_q ? s1_rready : s0_rready);
        s0_rvalid  = in_data & ~grant_q & m_rvalid;
        s1_rvalid  = in_data &  grant_q & m_rvalid;
        s0_rdata   = m_rdata;
        s0_rresp   = m_rresp;
        s1_rdata   = m_rdata;
        s1_rresp   = m_rresp;
    end

`ifndef SYNTHESIS
    // read data may only arrive once the address has been accepted
    a_no_early_rvalid: assert property (
        @(posedge clk) disable iff (!rst_n) (state_q != ST_DATA) |-> !m_rvalid
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_axil_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_rd_arbiter
// Purpose  : Self-checking bench for axil_rd_arbiter with directed scenarios
//            and randomized transactions against a transaction-level model.
// Options  : AXIL_RD_ARB_LSU_PRIORITY_EN selects the fixed-priority model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_rd_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s0_arvalid, s1_arvalid;
    logic [ADDR_W-1:0] s0_araddr, s1_araddr;
    logic              s0_arready, s1_arready;
    logic              s0_rvalid, s1_rvalid;
    logic [DATA_W-1:0] s0_rdata, s1_rdata;
    logic [1:0]        s0_rresp, s1_rresp;
    logic              s0_rready, s1_rready;
    logic              m_arvalid;
    logic [ADDR_W-1:0] m_araddr;
    logic              m_arready;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rready;

    int errors = 0;
    int checks = 0;
    int rr_last_m;   // model: last requester granted

    axil_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arready(s0_arready),
        .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rready(s0_rready),
        .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arready(s1_arready),
        .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rready(s1_rready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // model arbitration rule: lone requester wins; ties by policy
    function automatic int exp_win(input logic v0, input logic v1, input int last);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
`ifdef AXIL_RD_ARB_LSU_PRIORITY_EN
        return 1;
`else
        return (last == 0) ? 1 : 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        s0_arvalid = 0; s1_arvalid = 0; s0_rready = 0; s1_rready = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00;
    endtask

    task automatic test_reset();
        int w;
        logic [ADDR_W-1:0] ea;
        idle_inputs();
        rst_n = 0;
        s0_arvalid = 1; s1_arvalid = 1; s0_araddr = 64'h1000; s1_araddr = 64'h2000;
        repeat (3) tick();
        #1;
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL rst_m_arvalid got=%b exp=0", m_arvalid); end
        checks++; if (m_araddr !== '0) begin errors++; $display("FAIL rst_m_araddr got=%h exp=0", m_araddr); end
        checks++; if ({s0_arready, s1_arready} !== 2'b00) begin errors++; $display("FAIL rst_arready got=%b%b exp=00", s0_arready, s1_arready); end
        checks++; if ({s0_rvalid, s1_rvalid, m_rready} !== 3'b000) begin errors++; $display("FAIL rst_rvalid_rready got=%b%b%b exp=000", s0_rvalid, s1_rvalid, m_rready); end
        rr_last_m = 1;
        rst_n = 1;
        #1;
        w = exp_win(1, 1, rr_last_m);
        checks++; if ({s1_arready, s0_arready} !== ((w == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL first_tie got s0=%b s1=%b exp_winner=%0d", s0_arready, s1_arready, w); end
        rr_last_m = w;
        ea = (w == 1) ? s1_araddr : s0_araddr;
        tick();
        s0_arvalid = 0; s1_arvalid = 0;
        #1;
        checks++; if (m_arvalid !== 1'b1 || m_araddr !== ea) begin errors++; $display("FAIL first_issue got v=%b a=%h exp v=1 a=%h", m_arvalid, m_araddr, ea); end
        m_arready = 1;
        tick();
        m_arready = 0; m_rvalid = 1; m_rdata = 32'h1234_5678; s0_rready = 1; s1_rready = 1;
        #1;
        checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL first_rready got=%b exp=1", m_rready); end
        tick();
        idle_inputs();
    endtask

    task automatic test_single_s1();
        s1_arvalid = 1; s1_araddr = 64'h2008;
        #1;
        checks++; if ({s0_arready, s1_arready} !== 2'b01) begin errors++; $display("FAIL s1_accept got s0=%b s1=%b exp s0=0 s1=1", s0_arready, s1_arready); end
        rr_last_m = 1;
        tick();
        s1_arvalid = 0; m_arready = 1;
        #1;
        checks++; if (m_arvalid !== 1'b1 || m_araddr !== 64'h2008) begin errors++; $display("FAIL s1_issue got v=%b a=%h exp v=1 a=2008", m_arvalid, m_araddr); end
        tick();
        m_arready = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF; m_rresp = 2'b10; s1_rready = 1;
        #1;
        checks++; if (s1_rvalid !== 1'b1 || s1_rdata !== 32'hDEADBEEF || s1_rresp !== 2'b10) begin errors++; $display("FAIL s1_data got v=%b d=%h r=%b exp v=1 d=deadbeef r=10", s1_rvalid, s1_rdata, s1_rresp); end
        checks++; if (s0_rvalid !== 1'b0 || m_rready !== 1'b1) begin errors++; $display("FAIL s1_route got s0_rvalid=%b m_rready=%b exp 0 1", s0_rvalid, m_rready); end
        tick();
        idle_inputs();
        #1;
        checks++; if (s1_rvalid !== 1'b0 || m_arvalid !== 1'b0) begin errors++; $display("FAIL s1_done got rvalid=%b arvalid=%b exp 0 0", s1_rvalid, m_arvalid); end
    endtask

    task automatic test_back_to_back();
        int w;
        int grants[$];
        s0_arvalid = 1; s1_arvalid = 1; s0_araddr = 64'h1000; s1_araddr = 64'h2000;
        m_arready = 1; s0_rready = 1; s1_rready = 1;
        for (int k = 0; k < 4; k++) begin
            m_rvalid = 0;
            #1;
            w = exp_win(1, 1, rr_last_m);
            checks++; if ({s1_arready, s0_arready} !== ((w == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_grant%0d got s0=%b s1=%b exp_winner=%0d", k, s0_arready, s1_arready, w); end
            grants.push_back(w);
            rr_last_m = w;
            tick();
            #1;
            checks++; if ({s0_arready, s1_arready} !== 2'b00 || m_arvalid !== 1'b1 || m_araddr !== ((w == 1) ? 64'h2000 : 64'h1000)) begin errors++; $display("FAIL b2b_addr%0d got rdy=%b%b v=%b a=%h", k, s0_arready, s1_arready, m_arvalid, m_araddr); end
            tick();
            m_rvalid = 1; m_rdata = 32'hA000_0000 + k;
            #1;
            checks++; if ({s1_rvalid, s0_rvalid} !== ((w == 1) ? 2'b10 : 2'b01) || {s0_arready, s1_arready} !== 2'b00) begin errors++; $display("FAIL b2b_data%0d got s0_rvalid=%b s1_rvalid=%b exp_grant=%0d", k, s0_rvalid, s1_rvalid, w); end
            tick();
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
`ifdef AXIL_RD_ARB_LSU_PRIORITY_EN
            checks++; if (grants[k] != 1) begin errors++; $display("FAIL b2b_seq%0d got=%0d exp=1", k, grants[k]); end
`else
            checks++; if (grants[k] != (k % 2)) begin errors++; $display("FAIL b2b_seq%0d got=%0d exp=%0d", k, grants[k], k % 2); end
`endif
        end
    endtask

    task automatic test_addr_hold_and_backpressure();
        s0_arvalid = 1; s0_araddr = 64'h1000;
        #1;
        checks++; if (s0_arready !== 1'b1) begin errors++; $display("FAIL hold_accept got=%b exp=1", s0_arready); end
        rr_last_m = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            s0_araddr = 64'h1004;
            #1;
            checks++; if (m_araddr !== 64'h1000 || m_arvalid !== 1'b1 || s0_arready !== 1'b0) begin errors++; $display("FAIL hold_addr%0d got a=%h v=%b rdy=%b exp a=1000 v=1 rdy=0", i, m_araddr, m_arvalid, s0_arready); end
            tick();
        end
        m_arready = 1;
        tick();
        m_arready = 0; m_rvalid = 1; m_rdata = 32'hCAFE_F00D; s0_rready = 0; s1_rready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (m_rready !== 1'b0 || s0_rvalid !== 1'b1 || s1_rvalid !== 1'b0) begin errors++; $display("FAIL bp_stall%0d got m_rready=%b s0_rvalid=%b s1_rvalid=%b exp 0 1 0", i, m_rready, s0_rvalid, s1_rvalid); end
            tick();
        end
        s0_rready = 1;
        #1;
        checks++; if (m_rready !== 1'b1 || s0_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL bp_release got m_rready=%b d=%h exp 1 cafef00d", m_rready, s0_rdata); end
        tick();
        m_rvalid = 0;
        #1;
        checks++; if (s0_arready !== 1'b1 || s0_rvalid !== 1'b0) begin errors++; $display("FAIL bp_idle got arready=%b rvalid=%b exp 1 0", s0_arready, s0_rvalid); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_data();
        int w;
        s0_arvalid = 1; s0_araddr = 64'h3000;
        #1;
        checks++; if (s0_arready !== 1'b1) begin errors++; $display("FAIL mrst_accept got=%b exp=1", s0_arready); end
        tick();
        s0_arvalid = 0; m_arready = 1;
        tick();
        m_arready = 0; m_rvalid = 1; s0_rready = 1;
        #1;
        checks++; if (s0_rvalid !== 1'b1) begin errors++; $display("FAIL mrst_in_data got=%b exp=1", s0_rvalid); end
        #1;
        rst_n = 0; s0_arvalid = 1; s1_arvalid = 1;
        #1;
        checks++; if ({s0_rvalid, s1_rvalid, m_rready, m_arvalid, s0_arready, s1_arready} !== 6'b0) begin errors++; $display("FAIL mrst_drop got rv=%b%b mrr=%b mav=%b ar=%b%b exp all 0", s0_rvalid, s1_rvalid, m_rready, m_arvalid, s0_arready, s1_arready); end
        m_rvalid = 0;
        tick(); tick();
        rst_n = 1;
        rr_last_m = 1;
        #1;
        w = exp_win(1, 1, rr_last_m);
        checks++; if ({s1_arready, s0_arready} !== ((w == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL mrst_tie got s0=%b s1=%b exp_winner=%0d", s0_arready, s1_arready, w); end
        idle_inputs();
        tick();
        #1;
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL mrst_no_issue got=%b exp=0", m_arvalid); end
    endtask

    task automatic test_random();
        int w, v, keep, d1, d2, d3;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] rd;
        logic [1:0] rr;
        for (int t = 0; t < 40; t++) begin
            v = $urandom_range(1, 3);
            s0_arvalid = v[0]; s1_arvalid = v[1];
            s0_araddr = {$urandom, $urandom}; s1_araddr = {$urandom, $urandom};
            #1;
            w = exp_win(v[0], v[1], rr_last_m);
            checks++; if ({s1_arready, s0_arready} !== ((w == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd%0d_grant got s0=%b s1=%b exp_winner=%0d", t, s0_arready, s1_arready, w); end
            rr_last_m = w;
            ea = (w == 1) ? s1_araddr : s0_araddr;
            tick();
            keep = $urandom_range(0, 1);
            if (keep == 0) begin s0_arvalid = 0; s1_arvalid = 0; end
            d1 = $urandom_range(0, 3);
            for (int i = 0; i <= d1; i++) begin
                s0_araddr = {$urandom, $urandom}; s1_araddr = {$urandom, $urandom};
                m_arready = (i == d1);
                #1;
                checks++; if (m_arvalid !== 1'b1 || m_araddr !== ea || {s0_arready, s1_arready} !== 2'b00) begin errors++; $display("FAIL rnd%0d_addr got v=%b a=%h rdy=%b%b exp v=1 a=%h rdy=00", t, m_arvalid, m_araddr, s0_arready, s1_arready, ea); end
                tick();
            end
            m_arready = 0;
            d2 = $urandom_range(0, 2);
            for (int i = 0; i < d2; i++) begin
                #1;
                checks++; if ({s0_rvalid, s1_rvalid, m_arvalid} !== 3'b000) begin errors++; $display("FAIL rnd%0d_wait got rv=%b%b av=%b exp 000", t, s0_rvalid, s1_rvalid, m_arvalid); end
                tick();
            end
            rd = $urandom; rr = 2'($urandom_range(0, 3));
            m_rvalid = 1; m_rdata = rd; m_rresp = rr;
            d3 = $urandom_range(0, 2);
            for (int i = 0; i <= d3; i++) begin
                if (w == 1) begin s1_rready = (i == d3); s0_rready = 1'($urandom); end
                else        begin s0_rready = (i == d3); s1_rready = 1'($urandom); end
                #1;
                checks++;
                if ({s1_rvalid, s0_rvalid} !== ((w == 1) ? 2'b10 : 2'b01) || m_rready !== (i == d3)
                    || ((w == 1) ? s1_rdata : s0_rdata) !== rd || ((w == 1) ? s1_rresp : s0_rresp) !== rr
                    || {s0_arready, s1_arready} !== 2'b00) begin
                    errors++;
                    $display("FAIL rnd%0d_data got rv=%b%b mrr=%b d0=%h d1=%h exp grant=%0d mrr=%0d d=%h", t, s0_rvalid, s1_rvalid, m_rready, s0_rdata, s1_rdata, w, (i == d3), rd);
                end
                tick();
            end
            idle_inputs();
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        s0_araddr = '0; s1_araddr = '0;
        rr_last_m = 1;
        test_reset();
        test_single_s1();
        test_back_to_back();
        test_addr_hold_and_backpressure();
        test_reset_mid_data();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
